// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: IDLE/WAIT/DONE handshake to the data bus with lane steering and ack timeout.
// Optional misalignment trap (adel/ades, bad_vaddr) compiled in with MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] mem_pc,
    input  logic        stall_hold,
    output logic        dreq,
    output logic        dwe,
    output logic [31:0] daddr,
    output logic [3:0]  dsel,
    output logic [31:0] dwdata,
    input  logic [31:0] drdata,
    input  logic        dack,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        bus_err,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] TMO    = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic [7:0]  op_q;
    logic [1:0]  lane_q;
    logic        st_q;
    logic        err_q;

    logic        is_mem, is_store, is_half, is_word, misalign, start;
    logic [1:0]  lane;
    logic [3:0]  sel_nxt;
    logic [31:0] wdata_nxt, shifted, load_data;

    // PC is carried for future exception reporting; not needed for the access itself
    logic unused_pc;
    assign unused_pc = ^mem_pc;

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (mem_aluop)
            OP_LB, OP_LBU: is_mem = 1'b1;
            OP_LH, OP_LHU: begin is_mem = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_mem = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_mem = 1'b1; is_store = 1'b1; end
            OP_SH:         begin is_mem = 1'b1; is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_mem = 1'b1; is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_half && mem_mem_addr[0]) || (is_word && (mem_mem_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign start = (state == IDLE) && is_mem && !misalign;

    // Low address bits the access size cannot use are dropped, so the access lands aligned
    assign lane = is_word ? 2'b00 : (is_half ? {mem_mem_addr[1], 1'b0} : mem_mem_addr[1:0]);

    always_comb begin
        sel_nxt   = 4'b1111;
        wdata_nxt = mem_reg2;
        if (is_half) begin
            sel_nxt   = 4'b0011 << lane;
            wdata_nxt = {2{mem_reg2[15:0]}};
        end else if (!is_word) begin
            sel_nxt   = 4'b0001 << lane;
            wdata_nxt = {4{mem_reg2[7:0]}};
        end
    end

    assign shifted = drdata >> {lane_q, 3'b000};

    always_comb begin
        load_data = drdata;
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'd0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'd0, shifted[15:0]};
            default: load_data = drdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            rdata_q <= 32'd0;
            dreq    <= 1'b0;
            dwe     <= 1'b0;
            dsel    <= 4'd0;
            daddr   <= 32'd0;
            dwdata  <= 32'd0;
            bus_err <= 1'b0;
            op_q    <= 8'd0;
            lane_q  <= 2'd0;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dreq   <= 1'b1;
                        dwe    <= is_store;
                        dsel   <= sel_nxt;
                        daddr  <= {mem_mem_addr[31:2], 2'b00};
                        dwdata <= wdata_nxt;
                        cnt    <= 8'd1;
                        op_q   <= mem_aluop;
                        lane_q <= lane;
                        st_q   <= is_store;
                        err_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    // An ack on the timeout cycle still completes the access
                    if (dack) begin
                        rdata_q <= load_data;
                        dreq    <= 1'b0;
                        dwe     <= 1'b0;
                        dsel    <= 4'd0;
                    end else if (cnt == TMO) begin
                        dreq    <= 1'b0;
                        dwe     <= 1'b0;
                        dsel    <= 4'd0;
                        bus_err <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        wb_wd     = mem_wd;
        wb_wreg   = mem_wreg;
        wb_wdata  = mem_wdata;
        adel      = 1'b0;
        ades      = 1'b0;
        bad_vaddr = 32'd0;
        case (state)
            IDLE: begin
                if (is_mem && !rst) begin
                    wb_wreg = 1'b0;
                    if (misalign) begin
                        adel      = !is_store;
                        ades      = is_store;
                        bad_vaddr = mem_mem_addr;
                    end else begin
                        stallreq  = 1'b1;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stallreq = 1'b1;
                wb_wreg  = 1'b0;
                if (dack || cnt == TMO)
                    state_nxt = DONE;
            end
            DONE: begin
                if (st_q || err_q)
                    wb_wreg = 1'b0;
                else
                    wb_wdata = rdata_q;
                if (!stall_hold)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk, rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata, mem_mem_addr, mem_reg2, mem_pc;
    logic [7:0]  mem_aluop;
    logic        stall_hold;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dsel;
    logic        dack;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq, bus_err, adel, ades;
    logic [31:0] bad_vaddr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic        done;
        logic        aerr;
        logic [31:0] daddr;
        logic [3:0]  dsel;
        logic        dwe;
        logic [31:0] dwdata;
        logic [7:0]  stall;
        logic [7:0]  dreq_cnt;
        logic        dreq_done;
        logic        berr;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        berr_after;
        logic        dreq_after;
        logic        stall_after;
        logic [31:0] wdata_after;
    } obs_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rd;
        logic [7:0]  ack;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dwd;
        logic        wreg;
        logic [31:0] wdata;
    } vec_t;

    mem_access_unit #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .mem_pc(mem_pc), .stall_hold(stall_hold),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dsel(dsel), .dwdata(dwdata),
        .drdata(drdata), .dack(dack),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .bus_err(bus_err), .adel(adel), .ades(ades),
        .bad_vaddr(bad_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_nop();
        mem_aluop = 8'h00; mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
        mem_mem_addr = 32'd0; mem_reg2 = 32'd0;
    endtask

    // Issue one access, ack it in WAIT cycle ack_at (0 = never) and watch it to DONE and one cycle beyond
    task automatic bus_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input int ack_at, input logic [31:0] rd, output obs_t o);
        o = '0;
        @(posedge clk); #1;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'h5555_AAAA; mem_pc = 32'h0000_1000;
        drdata = rd; dack = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            dack = 1'b0;
            if (c == 0) o.aerr = adel | ades;
            if (c == 1) begin
                o.daddr = daddr; o.dsel = dsel; o.dwe = dwe; o.dwdata = dwdata;
            end
            if (dreq) o.dreq_cnt++;
            if (!stallreq) begin
                o.done = 1'b1; o.dreq_done = dreq; o.berr = bus_err;
                o.wd = wb_wd; o.wreg = wb_wreg; o.wdata = wb_wdata;
                break;
            end
            o.stall++;
            if (ack_at != 0 && c == ack_at) dack = 1'b1;
        end
        dack = 1'b0;
        @(posedge clk); #1;
        set_nop();
        @(negedge clk);
        o.berr_after = bus_err; o.dreq_after = dreq;
        o.stall_after = stallreq; o.wdata_after = wb_wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({dreq, dwe, dsel, bus_err, adel, ades, stallreq} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got dreq=%b dwe=%b dsel=%b berr=%b adel=%b ades=%b stall=%b, want all 0",
                     dreq, dwe, dsel, bus_err, adel, ades, stallreq);
        end
        n_cmp++;
        if (bad_vaddr !== 32'd0) begin
            n_err++; $display("FAIL reset_badvaddr: got %h want 0", bad_vaddr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [7:0] ops [3];
        exp_t e;
        ops[0] = 8'h00; ops[1] = 8'h21; ops[2] = 8'hE2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_aluop = ops[i]; mem_wd = 5'(i + 3); mem_wreg = i[0];
            mem_wdata = $urandom; mem_mem_addr = 32'h0000_0101;
            sb.push_back('{wreg: i[0], wdata: mem_wdata});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (wb_wd !== 5'(i + 3) || wb_wreg !== e.wreg || wb_wdata !== e.wdata) begin
                n_err++;
                $display("FAIL passthru[%0d]: got wd=%0d wreg=%b wdata=%h, want wd=%0d wreg=%b wdata=%h",
                         i, wb_wd, wb_wreg, wb_wdata, i + 3, e.wreg, e.wdata);
            end
            n_cmp++;
            if (stallreq !== 1'b0 || dreq !== 1'b0) begin
                n_err++; $display("FAIL passthru_stall[%0d]: got stall=%b dreq=%b want 0 0", i, stallreq, dreq);
            end
        end
    endtask

    task automatic test_lanes();
        vec_t v [10];
        obs_t o;
        exp_t e;
        v[0] = '{OP_LW,  32'h100, 32'h0,        32'hDEAD_BEEF, 8'd2, 4'b1111, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF};
        v[1] = '{OP_LB,  32'h103, 32'h0,        32'h80FF_0000, 8'd1, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFF_FF80};
        v[2] = '{OP_LBU, 32'h103, 32'h0,        32'h80FF_0000, 8'd1, 4'b1000, 1'b0, 32'h0,        1'b1, 32'h0000_0080};
        v[3] = '{OP_SH,  32'h202, 32'h1234_ABCD, 32'h0,        8'd1, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b0, 32'h0};
        v[4] = '{OP_LH,  32'h102, 32'h0,        32'h8001_7FFF, 8'd3, 4'b1100, 1'b0, 32'h0,        1'b1, 32'hFFFF_8001};
        v[5] = '{OP_LHU, 32'h100, 32'h0,        32'h8001_F0F0, 8'd1, 4'b0011, 1'b0, 32'h0,        1'b1, 32'h0000_F0F0};
        v[6] = '{OP_SB,  32'h101, 32'hCAFE_005A, 32'h0,        8'd2, 4'b0010, 1'b1, 32'h5A5A_5A5A, 1'b0, 32'h0};
        v[7] = '{OP_SW,  32'h300, 32'h0BAD_CAFE, 32'h0,        8'd1, 4'b1111, 1'b1, 32'h0BAD_CAFE, 1'b0, 32'h0};
        v[8] = '{OP_LB,  32'h100, 32'h0,        32'h1234_5678, 8'd1, 4'b0001, 1'b0, 32'h0,        1'b1, 32'h0000_0078};
        // ack on the same cycle the timeout would fire: the load completes normally
        v[9] = '{OP_LW,  32'h104, 32'h0,        32'h0F0F_0F0F, 8'd4, 4'b1111, 1'b0, 32'h0,        1'b1, 32'h0F0F_0F0F};
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{wreg: v[i].wreg, wdata: v[i].wdata});
            bus_txn(v[i].op, v[i].addr, v[i].reg2, int'(v[i].ack), v[i].rd, o);
            e = sb.pop_front();
            n_cmp++;
            if (o.done !== 1'b1 || o.stall !== 8'(v[i].ack + 1)) begin
                n_err++; $display("FAIL lat[%0d]: got done=%b stall=%0d want 1 %0d", i, o.done, o.stall, v[i].ack + 1);
            end
            n_cmp++;
            if (o.daddr !== {v[i].addr[31:2], 2'b00} || o.dsel !== v[i].sel || o.dwe !== v[i].we) begin
                n_err++;
                $display("FAIL bus[%0d]: got daddr=%h dsel=%b dwe=%b want daddr=%h dsel=%b dwe=%b",
                         i, o.daddr, o.dsel, o.dwe, {v[i].addr[31:2], 2'b00}, v[i].sel, v[i].we);
            end
            if (v[i].we) begin
                n_cmp++;
                if (o.dwdata !== v[i].dwd) begin
                    n_err++; $display("FAIL dwdata[%0d]: got %h want %h", i, o.dwdata, v[i].dwd);
                end
            end
            n_cmp++;
            if (o.wreg !== e.wreg || (e.wreg && (o.wdata !== e.wdata || o.wd !== 5'd7))) begin
                n_err++;
                $display("FAIL wb[%0d]: got wreg=%b wdata=%h wd=%0d want wreg=%b wdata=%h wd=7",
                         i, o.wreg, o.wdata, o.wd, e.wreg, e.wdata);
            end
            n_cmp++;
            if (o.dreq_done !== 1'b0 || o.berr !== 1'b0 || o.dreq_cnt !== v[i].ack) begin
                n_err++;
                $display("FAIL done_bus[%0d]: got dreq=%b berr=%b dreq_cycles=%0d want 0 0 %0d",
                         i, o.dreq_done, o.berr, o.dreq_cnt, v[i].ack);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb.push_back('{wreg: 1'b0, wdata: 32'h0});
        bus_txn(OP_LW, 32'h500, 32'h0, 0, 32'h1111_1111, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.dreq_cnt !== 8'd4 || o.stall !== 8'd5 || o.dreq_done !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_req: got dreq_cycles=%0d stall=%0d dreq_done=%b want 4 5 0",
                     o.dreq_cnt, o.stall, o.dreq_done);
        end
        n_cmp++;
        if (o.berr !== 1'b1 || o.berr_after !== 1'b0) begin
            n_err++; $display("FAIL timeout_berr: got %b then %b want 1 then 0", o.berr, o.berr_after);
        end
        n_cmp++;
        if (o.wreg !== e.wreg) begin
            n_err++; $display("FAIL timeout_wreg: got %b want %b", o.wreg, e.wreg);
        end
    endtask

    task automatic test_hold();
        obs_t o;
        exp_t e;
        stall_hold = 1'b1;
        sb.push_back('{wreg: 1'b1, wdata: 32'h1357_9BDF});
        bus_txn(OP_LW, 32'h010, 32'h0, 1, 32'h1357_9BDF, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.wdata !== e.wdata || o.wdata_after !== e.wdata || o.stall_after !== 1'b0 || o.dreq_after !== 1'b0) begin
            n_err++;
            $display("FAIL hold_done: got wdata=%h/%h stall=%b dreq=%b want %h/%h 0 0",
                     o.wdata, o.wdata_after, o.stall_after, o.dreq_after, e.wdata, e.wdata);
        end
        @(posedge clk); #1;
        stall_hold = 1'b0;
        @(posedge clk); #1;
        mem_wdata = 32'h2468_ACE0; mem_wreg = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (wb_wdata !== 32'h2468_ACE0 || stallreq !== 1'b0) begin
            n_err++; $display("FAIL hold_release: got wdata=%h stall=%b want 2468ace0 0", wb_wdata, stallreq);
        end
        set_nop();
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        logic [7:0]  ops   [3];
        logic [31:0] addrs [3];
        logic [1:0]  want  [3];
        ops[0] = OP_LW; addrs[0] = 32'h101; want[0] = 2'b10;
        ops[1] = OP_SW; addrs[1] = 32'h102; want[1] = 2'b01;
        ops[2] = OP_LH; addrs[2] = 32'h201; want[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_aluop = ops[i]; mem_mem_addr = addrs[i]; mem_wreg = 1'b1; mem_wd = 5'd9;
            @(negedge clk);
            n_cmp++;
            if ({adel, ades} !== want[i] || bad_vaddr !== addrs[i] || stallreq !== 1'b0 || wb_wreg !== 1'b0) begin
                n_err++;
                $display("FAIL misalign[%0d]: got adel=%b ades=%b bad=%h stall=%b wreg=%b want %b %h 0 0",
                         i, adel, ades, bad_vaddr, stallreq, wb_wreg, want[i], addrs[i]);
            end
            @(posedge clk); #1;
            set_nop();
            @(negedge clk);
            n_cmp++;
            if (dreq !== 1'b0 || adel !== 1'b0 || ades !== 1'b0) begin
                n_err++; $display("FAIL misalign_nobus[%0d]: got dreq=%b adel=%b ades=%b want 0", i, dreq, adel, ades);
            end
        end
`else
        obs_t o;
        exp_t e;
        sb.push_back('{wreg: 1'b1, wdata: 32'hA5A5_0001});
        bus_txn(OP_LW, 32'h101, 32'h0, 1, 32'hA5A5_0001, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.aerr !== 1'b0 || o.daddr !== 32'h100 || o.dsel !== 4'b1111 || o.wdata !== e.wdata || o.wreg !== e.wreg) begin
            n_err++;
            $display("FAIL unaligned_lw: got aerr=%b daddr=%h dsel=%b wdata=%h wreg=%b want 0 100 1111 %h 1",
                     o.aerr, o.daddr, o.dsel, o.wdata, o.wreg, e.wdata);
        end
        bus_txn(OP_SH, 32'h203, 32'h0000_7E7E, 1, 32'h0, o);
        n_cmp++;
        if (o.aerr !== 1'b0 || o.daddr !== 32'h200 || o.dsel !== 4'b1100 || o.dwdata !== 32'h7E7E_7E7E) begin
            n_err++;
            $display("FAIL unaligned_sh: got aerr=%b daddr=%h dsel=%b dwdata=%h want 0 200 1100 7e7e7e7e",
                     o.aerr, o.daddr, o.dsel, o.dwdata);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        exp_t e;
        @(posedge clk); #1;
        mem_aluop = OP_LW; mem_mem_addr = 32'h400; mem_wreg = 1'b1; mem_wd = 5'd4; dack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dreq !== 1'b1 || stallreq !== 1'b1) begin
            n_err++; $display("FAIL rstwait_pre: got dreq=%b stall=%b want 1 1", dreq, stallreq);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_nop();
        mem_wreg = 1'b1; mem_wdata = 32'h0BAD_F00D; mem_wd = 5'd12;
        drdata = 32'hFFFF_FFFF; dack = 1'b1;
        sb.push_back('{wreg: 1'b1, wdata: 32'h0BAD_F00D});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            e = sb[0];
            n_cmp++;
            if (dreq !== 1'b0 || stallreq !== 1'b0 || wb_wreg !== e.wreg || wb_wdata !== e.wdata || wb_wd !== 5'd12) begin
                n_err++;
                $display("FAIL rstwait_post[%0d]: got dreq=%b stall=%b wreg=%b wdata=%h wd=%0d want 0 0 1 %h 12",
                         c, dreq, stallreq, wb_wreg, wb_wdata, e.wdata, wb_wd);
            end
            @(posedge clk); #1;
        end
        void'(sb.pop_front());
        dack = 1'b0;
        sb.push_back('{wreg: 1'b1, wdata: 32'h7654_3210});
        bus_txn(OP_LW, 32'h408, 32'h0, 2, 32'h7654_3210, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.done !== 1'b1 || o.wdata !== e.wdata || o.daddr !== 32'h408) begin
            n_err++; $display("FAIL rstwait_recover: got done=%b wdata=%h daddr=%h want 1 %h 408", o.done, o.wdata, o.daddr, e.wdata);
        end
    endtask

    initial begin
        rst = 1'b1; dack = 1'b0; drdata = 32'd0; stall_hold = 1'b0; mem_pc = 32'd0;
        set_nop();
        test_reset();
        test_passthrough();
        test_lanes();
        test_timeout();
        test_hold();
        test_misalign();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
